// File: rtl/bcd_seq_conv_if.sv
// Handshake bundle between a distance producer and the sequential BCD converter.
// The master drives the request and binary value; the slave returns the BCD result and status.
interface bcd_seq_conv_if #(
    parameter int BIN_W  = 24,
    parameter int DIGITS = 8
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    modport master (
        output start, bin,
        input  bcd, busy, done, overflow
    );

    modport slave (
        input  start, bin,
        output bcd, busy, done, overflow
    );
endinterface

// File: rtl/bcd_seq_conv.sv
// Sequential double-dabble binary-to-BCD converter: one shift per clock, result register
// updated only when a conversion completes, so the display never sees partial digits.
module bcd_seq_conv #(
    parameter int BIN_W  = 24,
    parameter int DIGITS = 8
) (
    input  logic           clk,
    input  logic           n_rst,
    bcd_seq_conv_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [BIN_W-1:0]  shift_reg;
    logic [BCD_W-1:0]  work_bcd;
    logic              ovf_flag;
    logic [CNT_W-1:0]  cnt;
    logic [BCD_W-1:0]  bcd_reg;
    logic              ovf_reg;

    logic [BCD_W-1:0]  adj_bcd;
    logic [BCD_W:0]    wide_bcd;
    logic [BCD_W-1:0]  nxt_bcd;
    logic [BIN_W-1:0]  nxt_shift;
    logic              nxt_ovf;
    logic              last;

    // Add-3 per 4-bit digit, then shift; the extra top bit of wide_bcd is the lost carry.
    always_comb begin
        adj_bcd = work_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_bcd[4*i +: 4] >= 4'd5) begin
                adj_bcd[4*i +: 4] = work_bcd[4*i +: 4] + 4'd3;
            end
        end
        wide_bcd  = {adj_bcd, shift_reg[BIN_W-1]};
        nxt_bcd   = wide_bcd[BCD_W-1:0];
        nxt_shift = {shift_reg[BIN_W-2:0], 1'b0};
        last      = (cnt == CNT_W'(1));
        nxt_ovf   = ovf_flag | wide_bcd[BCD_W]
                  | (last & (wide_bcd[BCD_W-1 -: 4] > 4'd9));
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = SHIFT;
            SHIFT:   if (last)      next_state = DONE;
            DONE:                   next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // The result register loads on the final shift so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            shift_reg <= '0;
            work_bcd  <= '0;
            ovf_flag  <= 1'b0;
            cnt       <= '0;
            bcd_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_reg <= bus.bin;
                        work_bcd  <= '0;
                        ovf_flag  <= 1'b0;
                        cnt       <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    shift_reg <= nxt_shift;
                    work_bcd  <= nxt_bcd;
                    ovf_flag  <= nxt_ovf;
                    cnt       <= cnt - CNT_W'(1);
                    if (last) begin
                        bcd_reg <= nxt_ovf ? ALL_NINES : nxt_bcd;
                        ovf_reg <= nxt_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.bcd      = bcd_reg;
    assign bus.overflow = ovf_reg;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
endmodule
